// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack control core and its instruction memory,
// data memory and ALU. master = CPU control core, slave = the surrounding system.
interface hack_cpu_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_data;

    logic              dmem_rd;
    logic              dmem_wr;
    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_wdata;
    logic [15:0]       dmem_rdata;
    logic              dmem_ack;

    logic [15:0]       alu_x;
    logic [15:0]       alu_y;
    logic              alu_zx;
    logic              alu_nx;
    logic              alu_zy;
    logic              alu_ny;
    logic              alu_f;
    logic              alu_no;
    logic [15:0]       alu_out;
    logic              alu_zr;
    logic              alu_ng;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        input  alu_out, alu_zr, alu_ng
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        output alu_out, alu_zr, alu_ng
    );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control core: FETCH/READ/EXEC/WRITE sequencer driving an external ALU.
// Optional macro HACK_HALT_DETECT_EN adds a HALT state for a jump-to-self loop.
module hack_cpu_ctrl #(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    hack_cpu_ctrl_if.master   bus,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [2:0] {
        FETCH,
        READ,
        EXEC,
        WRITE
`ifdef HACK_HALT_DETECT_EN
        , HALT
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       a_reg, a_next;
    logic [15:0]       d_reg, d_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       ir_reg, ir_next;
    logic [ADDR_W-1:0] al_reg, al_next;
    logic [15:0]       mr_reg, mr_next;
    logic [15:0]       wd_reg, wd_next;

    logic req_c, rd_c, wr_c, retire_c;
    logic jump_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            a_reg     <= '0;
            d_reg     <= '0;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
            al_reg    <= '0;
            mr_reg    <= '0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            d_reg     <= d_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            al_reg    <= al_next;
            mr_reg    <= mr_next;
            wd_reg    <= wd_next;
        end
    end

    assign jump_taken = (ir_reg[2] & bus.alu_ng) | (ir_reg[1] & bus.alu_zr) |
                        (ir_reg[0] & ~bus.alu_zr & ~bus.alu_ng);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        d_next     = d_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        al_next    = al_reg;
        mr_next    = mr_reg;
        wd_next    = wd_reg;
        req_c      = 1'b0;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        retire_c   = 1'b0;
        case (state_reg)
            FETCH: begin
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_next    = bus.imem_data;
                    al_next    = a_reg[ADDR_W-1:0];
                    state_next = (bus.imem_data[15] & bus.imem_data[12]) ? READ : EXEC;
                end
            end
            READ: begin
                rd_c = 1'b1;
                if (bus.dmem_ack) begin
                    mr_next    = bus.dmem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!ir_reg[15]) begin
                    a_next     = {1'b0, ir_reg[14:0]};
                    pc_next    = pc_reg + 1'b1;
                    retire_c   = 1'b1;
                    state_next = FETCH;
                end else begin
                    if (ir_reg[5]) a_next = bus.alu_out;
                    if (ir_reg[4]) d_next = bus.alu_out;
                    // Jump target is A as it stood before this instruction's own A write.
                    pc_next = jump_taken ? a_reg[ADDR_W-1:0] : pc_reg + 1'b1;
                    if (ir_reg[3]) begin
                        wd_next    = bus.alu_out;
                        state_next = WRITE;
                    end else begin
                        retire_c   = 1'b1;
                        state_next = FETCH;
`ifdef HACK_HALT_DETECT_EN
                        if (ir_reg[2:0] == 3'b111 && a_reg[ADDR_W-1:0] == pc_reg)
                            state_next = HALT;
`endif
                    end
                end
            end
            WRITE: begin
                wr_c = 1'b1;
                if (bus.dmem_ack) begin
                    retire_c   = 1'b1;
                    state_next = FETCH;
                end
            end
`ifdef HACK_HALT_DETECT_EN
            HALT: begin
                state_next = HALT;
            end
`endif
            default: state_next = FETCH;
        endcase
    end

    // Requests and retire are masked while reset is held so the bus is quiet during reset.
    assign bus.imem_req   = req_c & ~reset;
    assign bus.imem_addr  = pc_reg;
    assign bus.dmem_rd    = rd_c & ~reset;
    assign bus.dmem_wr    = wr_c & ~reset;
    assign bus.dmem_addr  = al_reg;
    assign bus.dmem_wdata = wd_reg;

    assign bus.alu_x  = d_reg;
    assign bus.alu_y  = ir_reg[12] ? mr_reg : a_reg;
    assign bus.alu_zx = ir_reg[11];
    assign bus.alu_nx = ir_reg[10];
    assign bus.alu_zy = ir_reg[9];
    assign bus.alu_ny = ir_reg[8];
    assign bus.alu_f  = ir_reg[7];
    assign bus.alu_no = ir_reg[6];

    assign pc     = pc_reg;
    assign retire = retire_c & ~reset;
`ifdef HACK_HALT_DETECT_EN
    assign halted = (state_reg == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
